// File: rtl/bm_rd_sched.sv
// Buffer-memory read scheduler: round-robin burst arbitration between the conv and fc requesters,
// registered read issue, and an RD_LAT-deep tag pipeline that routes returned data to its owner.
module bm_rd_sched #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned LEN_WIDTH  = 12,
   parameter int unsigned RD_LAT     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_conv_i,
   input  logic [ADDR_WIDTH-1:0] base_conv_i,
   input  logic [LEN_WIDTH-1:0]  len_conv_i,
   output logic                  ack_conv_o,
   output logic [DATA_WIDTH-1:0] dout_conv_o,
   output logic                  dout_vld_conv_o,
   output logic                  done_conv_o,
   input  logic                  req_fc_i,
   input  logic [ADDR_WIDTH-1:0] base_fc_i,
   input  logic [LEN_WIDTH-1:0]  len_fc_i,
   output logic                  ack_fc_o,
   output logic [DATA_WIDTH-1:0] dout_fc_o,
   output logic                  dout_vld_fc_o,
   output logic                  done_fc_o,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [DATA_WIDTH-1:0] din_i
);

   typedef enum logic {StIdle, StIssue} state_e;

   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LenOne  = LEN_WIDTH'(1);

   state_e                state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  owner_q, owner_d;       // 1: fc owns the current burst
   logic                  stg_done_q, stg_done_d; // issue stage carries the burst's done marker
   logic                  last_fc_q, last_fc_d;   // 1: fc was granted last

   logic [RD_LAT-1:0]     pipe_vld_q, pipe_done_q, pipe_own_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  vld_conv_q, vld_fc_q, done_conv_q, done_fc_q;

   logic                  gnt_conv, gnt_fc;
   logic [LEN_WIDTH-1:0]  len_sel;

   // With both requesting, fc wins only if conv was granted last.
   assign gnt_fc   = (state_q == StIdle) & req_fc_i & (~req_conv_i | ~last_fc_q);
   assign gnt_conv = (state_q == StIdle) & req_conv_i & ~gnt_fc;
   assign len_sel  = gnt_fc ? len_fc_i : len_conv_i;

   always_comb begin
      state_d    = state_q;
      rd_en_d    = 1'b0;
      addr_d     = addr_q;
      rem_d      = rem_q;
      owner_d    = owner_q;
      stg_done_d = 1'b0;
      last_fc_d  = last_fc_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_conv || gnt_fc) begin
               state_d   = StIssue;
               owner_d   = gnt_fc;
               last_fc_d = gnt_fc;
               addr_d    = gnt_fc ? base_fc_i : base_conv_i;
               if (len_sel != '0) begin
                  rd_en_d    = 1'b1;
                  rem_d      = len_sel - LenOne;
                  stg_done_d = (len_sel == LenOne);
               end else begin
                  // Empty burst: a done-only marker rides the pipeline in place of a read.
                  rem_d      = '0;
                  stg_done_d = 1'b1;
               end
            end
         end
         StIssue: begin
            if (rem_q != '0) begin
               rd_en_d    = 1'b1;
               addr_d     = addr_q + AddrOne;
               rem_d      = rem_q - LenOne;
               stg_done_d = (rem_q == LenOne);
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         rem_q      <= '0;
         owner_q    <= 1'b0;
         stg_done_q <= 1'b0;
         last_fc_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         rd_en_q    <= rd_en_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         owner_q    <= owner_d;
         stg_done_q <= stg_done_d;
         last_fc_q  <= last_fc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q  <= '0;
         pipe_done_q <= '0;
         pipe_own_q  <= '0;
         dout_q      <= '0;
         vld_conv_q  <= 1'b0;
         vld_fc_q    <= 1'b0;
         done_conv_q <= 1'b0;
         done_fc_q   <= 1'b0;
      end else begin
         pipe_vld_q[0]  <= rd_en_q;
         pipe_done_q[0] <= stg_done_q;
         pipe_own_q[0]  <= owner_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_done_q[i] <= pipe_done_q[i-1];
            pipe_own_q[i]  <= pipe_own_q[i-1];
         end
         dout_q      <= din_i;
         vld_conv_q  <= pipe_vld_q[RD_LAT-1] & ~pipe_own_q[RD_LAT-1];
         vld_fc_q    <= pipe_vld_q[RD_LAT-1] & pipe_own_q[RD_LAT-1];
         done_conv_q <= pipe_done_q[RD_LAT-1] & ~pipe_own_q[RD_LAT-1];
         done_fc_q   <= pipe_done_q[RD_LAT-1] & pipe_own_q[RD_LAT-1];
      end
   end

   // Grants are combinational, so gate them to keep every output low during reset.
   assign ack_conv_o      = gnt_conv & rst_n;
   assign ack_fc_o        = gnt_fc & rst_n;
   assign rd_en_o         = rd_en_q;
   assign rd_addr_o       = addr_q;
   assign dout_conv_o     = dout_q;
   assign dout_fc_o       = dout_q;
   assign dout_vld_conv_o = vld_conv_q;
   assign dout_vld_fc_o   = vld_fc_q;
   assign done_conv_o     = done_conv_q;
   assign done_fc_o       = done_fc_q;

endmodule

// File: tb/tb_bm_rd_sched.sv
// Bench for bm_rd_sched: directed bursts plus a randomized two-requester run, checked against a
// burst-level schedule model and a latency-accurate BM memory model.
module tb_bm_rd_sched;

   localparam int AW   = 12;
   localparam int DW   = 64;
   localparam int LW   = 12;
   localparam int LAT  = 4;
   localparam int NCYC = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_conv_i = 1'b0, req_fc_i = 1'b0;
   logic [AW-1:0] base_conv_i = '0, base_fc_i = '0;
   logic [LW-1:0] len_conv_i = '0, len_fc_i = '0;
   logic          ack_conv_o, ack_fc_o, dout_vld_conv_o, dout_vld_fc_o, done_conv_o, done_fc_o;
   logic [DW-1:0] dout_conv_o, dout_fc_o, din_i;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;

   bm_rd_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_conv_i(req_conv_i), .base_conv_i(base_conv_i), .len_conv_i(len_conv_i),
      .ack_conv_o(ack_conv_o), .dout_conv_o(dout_conv_o), .dout_vld_conv_o(dout_vld_conv_o),
      .done_conv_o(done_conv_o),
      .req_fc_i(req_fc_i), .base_fc_i(base_fc_i), .len_fc_i(len_fc_i),
      .ack_fc_o(ack_fc_o), .dout_fc_o(dout_fc_o), .dout_vld_fc_o(dout_vld_fc_o),
      .done_fc_o(done_fc_o),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .din_i(din_i)
   );

   always #5 clk = ~clk;

   // BM model: word contents are a salted hash of the address, returned LAT cycles after rd_en.
   int unsigned salt;
   logic [LAT-1:0] hv = '0;
   int unsigned    ha [LAT];

   function automatic logic [DW-1:0] bm_word(int unsigned a);
      return {(a * 32'h9E3779B1) ^ salt, a ^ 32'hC0DE0000 ^ ~salt};
   endfunction

   always @(posedge clk) begin
      hv[0] <= rd_en_o;
      ha[0] <= int'(rd_addr_o);
      for (int k = 1; k < LAT; k++) begin
         hv[k] <= hv[k-1];
         ha[k] <= ha[k-1];
      end
   end

   always_comb din_i = hv[LAT-1] ? bm_word(ha[LAT-1]) : '0;

   // Stimulus state and expected per-cycle schedule.
   int  checks = 0, errors = 0, cyc = 0;
   bit  rq_c, rq_f;
   int  bs_c, bs_f, ln_c, ln_f;
   bit  e_rd [NCYC];
   int  e_addr [NCYC];
   bit  e_vc [NCYC], e_vf [NCYC], e_dc [NCYC], e_df [NCYC];
   logic [DW-1:0] e_data [NCYC];
   int  m_free;
   bit  m_last_fc, m_gc, m_gf;
   int  n_gc, n_gf, sum_c, sum_f, obs_bc, obs_bf, obs_dc, obs_df;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int t = cyc; t < NCYC; t++) begin
         e_rd[t] = 0; e_vc[t] = 0; e_vf[t] = 0; e_dc[t] = 0; e_df[t] = 0;
      end
      m_free = 0; m_last_fc = 1; m_gc = 0; m_gf = 0;
   endtask

   // A granted burst of L words issues on T+1..T+L, returns each word LAT+1 cycles after issue;
   // an empty burst only signals done at T+LAT+2. Next grant after one idle cycle.
   task automatic model_grant();
      int b, L, v;
      m_gc = 0; m_gf = 0;
      if (cyc >= m_free && (rq_c || rq_f)) begin
         m_gf = rq_f && (!rq_c || !m_last_fc);
         m_gc = !m_gf;
         b = m_gf ? bs_f : bs_c;
         L = m_gf ? ln_f : ln_c;
         for (int i = 0; i < L; i++) begin
            e_rd[cyc+1+i] = 1;
            e_addr[cyc+1+i] = (b + i) % (1 << AW);
            v = cyc + 1 + i + LAT + 1;
            if (m_gf) e_vf[v] = 1; else e_vc[v] = 1;
            e_data[v] = bm_word(unsigned'((b + i) % (1 << AW)));
            if (i == L - 1) begin
               if (m_gf) e_df[v] = 1; else e_dc[v] = 1;
            end
         end
         if (L == 0) begin
            if (m_gf) e_df[cyc+LAT+2] = 1; else e_dc[cyc+LAT+2] = 1;
         end
         m_free = cyc + ((L == 0) ? 1 : L) + 1;
         m_last_fc = m_gf;
         if (m_gf) begin n_gf++; sum_f += L; end
         else begin n_gc++; sum_c += L; end
      end
   endtask

   task automatic tick(bit rv);
      @(posedge clk);
      #1;
      cyc++;
      rst_n = rv;
      req_conv_i = rq_c; base_conv_i = AW'(bs_c); len_conv_i = LW'(ln_c);
      req_fc_i = rq_f; base_fc_i = AW'(bs_f); len_fc_i = LW'(ln_f);
      if (!rv) model_reset(); else model_grant();
      @(negedge clk);
      chk("ack_conv", 64'(ack_conv_o), 64'(m_gc));
      chk("ack_fc", 64'(ack_fc_o), 64'(m_gf));
      chk("rd_en", 64'(rd_en_o), 64'(e_rd[cyc]));
      if (e_rd[cyc]) chk("rd_addr", 64'(rd_addr_o), 64'(e_addr[cyc]));
      chk("dout_vld_conv", 64'(dout_vld_conv_o), 64'(e_vc[cyc]));
      chk("dout_vld_fc", 64'(dout_vld_fc_o), 64'(e_vf[cyc]));
      chk("done_conv", 64'(done_conv_o), 64'(e_dc[cyc]));
      chk("done_fc", 64'(done_fc_o), 64'(e_df[cyc]));
      if (e_vc[cyc]) chk("dout_conv", dout_conv_o, e_data[cyc]);
      if (e_vf[cyc]) chk("dout_fc", dout_fc_o, e_data[cyc]);
      if (!rv) begin
         chk("rst_dout_conv", dout_conv_o, 64'd0);
         chk("rst_dout_fc", dout_fc_o, 64'd0);
      end
      obs_bc += int'(dout_vld_conv_o); obs_bf += int'(dout_vld_fc_o);
      obs_dc += int'(done_conv_o);     obs_df += int'(done_fc_o);
   endtask

   // Drive the given requests, drop each one once the model grants it, then idle.
   task automatic burst(bit c, int bc, int lc, bit f, int bf, int lf, int idle);
      rq_c = c; bs_c = bc; ln_c = lc;
      rq_f = f; bs_f = bf; ln_f = lf;
      for (int n = 0; n < 60 && (rq_c || rq_f); n++) begin
         tick(1'b1);
         if (m_gc) rq_c = 0;
         if (m_gf) rq_f = 0;
      end
      chk("grant_budget", 64'(rq_c | rq_f), 64'd0);
      rq_c = 0; rq_f = 0;
      for (int n = 0; n < idle; n++) tick(1'b1);
   endtask

   initial begin
      int grants;
      salt = $urandom;
      rq_c = 0; rq_f = 0; bs_c = 0; bs_f = 0; ln_c = 0; ln_f = 0;
      model_reset();
      // Reset state, with a pending request that must not be acknowledged.
      rq_c = 1; ln_c = 3;
      for (int n = 0; n < 3; n++) tick(1'b0);
      rq_c = 0;
      tick(1'b1);
      // Single conv burst, then simultaneous requests, wrap, and an empty fc burst.
      burst(1, 'h010, 3, 0, 0, 0, 10);
      burst(1, 'h200, 2, 1, 'h300, 2, 10);
      burst(0, 0, 0, 1, 'hFFE, 4, 10);
      burst(0, 0, 0, 1, 'h123, 0, 10);
      // Reset two cycles into a long burst with reads in flight; request held across reset.
      rq_c = 1; bs_c = 'h040; ln_c = 8;
      tick(1'b1);
      rq_c = 0;
      tick(1'b1);
      tick(1'b1);
      rq_c = 1; bs_c = 'h100; ln_c = 2;
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      chk("first_grant_after_reset", 64'(ack_conv_o), 64'd1);
      rq_c = 0;
      for (int n = 0; n < 12; n++) tick(1'b1);
      // Both requesting continuously for 100 bursts of random length.
      n_gc = 0; n_gf = 0; sum_c = 0; sum_f = 0;
      obs_bc = 0; obs_bf = 0; obs_dc = 0; obs_df = 0;
      grants = 0;
      rq_c = 1; rq_f = 1;
      bs_c = $urandom_range(4095, 0); ln_c = $urandom_range(16, 1);
      bs_f = $urandom_range(4095, 0); ln_f = $urandom_range(16, 1);
      for (int n = 0; n < 4000 && grants < 100; n++) begin
         tick(1'b1);
         if (m_gc) begin grants++; bs_c = $urandom_range(4095, 0); ln_c = $urandom_range(16, 1); end
         if (m_gf) begin grants++; bs_f = $urandom_range(4095, 0); ln_f = $urandom_range(16, 1); end
      end
      rq_c = 0; rq_f = 0;
      for (int n = 0; n < 30; n++) tick(1'b1);
      chk("random_grants", 64'(grants), 64'd100);
      chk("grant_split_conv", 64'(n_gc), 64'd50);
      chk("beats_conv", 64'(obs_bc), 64'(sum_c));
      chk("beats_fc", 64'(obs_bf), 64'(sum_f));
      chk("dones_conv", 64'(obs_dc), 64'(n_gc));
      chk("dones_fc", 64'(obs_df), 64'(n_gf));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
